// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, flush and saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that registers the ready path.
module pipe_stage_reg #(
   parameter int unsigned DATA_W = 74,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic              w_accept;
   logic              w_pop;
   logic              w_stall;

   assign w_accept    = i_in_valid && o_in_ready;
   assign w_pop       = r_out_valid && i_out_ready;
   assign w_stall     = r_out_valid && !i_out_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_stall_cnt = r_stall_cnt;

`ifdef PIPE_STAGE_SKID_EN
   logic              r_skid_valid;
   logic [DATA_W-1:0] r_skid_data;

   // Ready depends only on held state, so out_ready never reaches in_ready.
   assign o_in_ready = !i_flush && !r_skid_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
      end else if (i_flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_pop && r_skid_valid) begin
         r_out_data   <= r_skid_data;
         r_skid_valid <= 1'b0;
      end else if (w_accept && (!r_out_valid || w_pop)) begin
         r_out_data  <= i_in_data;
         r_out_valid <= 1'b1;
      end else if (w_accept) begin
         r_skid_data  <= i_in_data;
         r_skid_valid <= 1'b1;
      end else if (w_pop) begin
         r_out_valid <= 1'b0;
      end
   end
`else
   assign o_in_ready = !i_flush && (!r_out_valid || i_out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (i_flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_data  <= i_in_data;
         r_out_valid <= 1'b1;
      end else if (w_pop) begin
         r_out_valid <= 1'b0;
      end
   end
`endif

   // Stall counter saturates and survives flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; a second instance with a 4-bit counter covers saturation.
module tb_pipe_stage_reg;

   localparam int unsigned DW = 74;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic [DW-1:0] in_data;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [15:0]   stall_cnt;
   logic          s_in_ready, s_out_valid;
   logic [DW-1:0] s_out_data;
   logic [3:0]    s_stall_cnt;

   int n_vec = 0;
   int n_err = 0;
   logic [DW-1:0] sb_q[$];
   int base_cnt;

   always #5 clk = ~clk;

   pipe_stage_reg u_dut (
      .clk(clk), .rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_data(in_data), .o_out_valid(out_valid), .i_out_ready(out_ready),
      .o_out_data(out_data), .o_stall_cnt(stall_cnt)
   );

   pipe_stage_reg #(.DATA_W(DW), .CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(s_in_ready),
      .i_in_data(in_data), .o_out_valid(s_out_valid), .i_out_ready(out_ready),
      .o_out_data(s_out_data), .o_stall_cnt(s_stall_cnt)
   );

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: events observed mid-cycle take effect at the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) check("sb_underflow", 80'(sb_q.size()), 80'(1));
            else check("sb_data", 80'(out_data), 80'(sb_q.pop_front()));
         end
         if (flush) sb_q.delete();
         else if (in_valid && in_ready) sb_q.push_back(in_data);
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = DW'(74'h1234); out_ready = 1'b1;
      // Reset with input presented
      tick(); tick();
      check("rst_valid", 80'(out_valid), 80'(0));
      check("rst_data", 80'(out_data), 80'(0));
      check("rst_cnt", 80'(stall_cnt), 80'(0));
      rst = 1'b0;
      tick();
      check("rel_valid", 80'(out_valid), 80'(1));
      check("rel_data", 80'(out_data), 80'(74'h1234));

      // Streaming
      for (int i = 1; i <= 4; i++) begin
         in_data = DW'(i);
         #1 check("str_ready", 80'(in_ready), 80'(1));
         tick();
         check("str_data", 80'(out_data), 80'(i));
         check("str_valid", 80'(out_valid), 80'(1));
         check("str_cnt", 80'(stall_cnt), 80'(0));
      end

      // Stall with bundle 7 held
      in_data = DW'(7);
      tick();
      out_ready = 1'b0; in_data = DW'(8);
`ifdef PIPE_STAGE_SKID_EN
      #1 check("stl_ready0", 80'(in_ready), 80'(1));
`else
      #1 check("stl_ready0", 80'(in_ready), 80'(0));
`endif
      for (int k = 1; k <= 5; k++) begin
         tick();
`ifdef PIPE_STAGE_SKID_EN
         in_valid = 1'b0;
         check("stl_skid_full", 80'(in_ready), 80'(0));
`endif
         check("stl_data", 80'(out_data), 80'(7));
      end
      check("stl_cnt", 80'(stall_cnt), 80'(5));
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("rel_data8", 80'(out_data), 80'(8));
      check("rel_valid8", 80'(out_valid), 80'(1));
      tick();
      check("drain_valid", 80'(out_valid), 80'(0));

      // Flush with the stage full
      out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(20);
      tick();
      base_cnt = 6;
`ifdef PIPE_STAGE_SKID_EN
      in_data = DW'(21);
      tick();
      base_cnt = 7;
`endif
      in_data = DW'(22); flush = 1'b1;
      #1 check("fl_ready", 80'(in_ready), 80'(0));
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_valid", 80'(out_valid), 80'(0));
      check("fl_cnt_kept", 80'(stall_cnt), 80'(base_cnt));
      out_ready = 1'b1; in_valid = 1'b1; in_data = DW'(30);
      tick();
      in_valid = 1'b0;
      check("post_fl_data", 80'(out_data), 80'(30));
      tick();

      // Saturation
      out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(40);
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      check("sat_cnt4", 80'(s_stall_cnt), 80'(15));
      check("sat_cnt16", 80'(stall_cnt), 80'(base_cnt + 20));
      check("sat_data", 80'(out_data), 80'(40));

      // Reset mid-stall
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b1; in_data = DW'(50);
      tick();
`ifdef PIPE_STAGE_SKID_EN
      in_data = DW'(51);
      tick();
      in_valid = 1'b0;
      tick(); tick();
`else
      in_valid = 1'b0;
      tick(); tick(); tick();
`endif
      check("mid_cnt3", 80'(stall_cnt), 80'(3));
      rst = 1'b1;
      tick();
      check("mid_cnt0", 80'(stall_cnt), 80'(0));
      check("mid_valid", 80'(out_valid), 80'(0));
      check("mid_ready", 80'(in_ready), 80'(1));
      rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = DW'(60);
      tick();
      in_valid = 1'b0;
      check("mid_first", 80'(out_data), 80'(60));
      tick(); tick();
      check("sb_drain", 80'(sb_q.size()), 80'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a packed control+data bundle of configurable width with a valid/ready handshake, so the hazard unit can stall a stage by holding `out_ready` low. It can also kill the stage's contents with `flush` on a branch or exception. A saturating stall counter supports performance analysis. An optional skid buffer breaks the combinational ready path between stages.

## Interface
- `DATA_W`, default 74: width of the packed stage bundle (e.g. {WB, M, ALU, WD, Rd}).
- `CNT_W`, default 16: width of the stall counter.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `flush` input 1: kill all held entries this cycle.
- `in_valid` input 1: upstream bundle valid.
- `in_ready` output 1: stage can accept a bundle this cycle.
- `in_data` input DATA_W: upstream bundle.
- `out_valid` output 1: `out_data` holds a live bundle.
- `out_ready` input 1: downstream accepts `out_data` this cycle.
- `out_data` output DATA_W: registered bundle.
- `stall_cnt` output CNT_W: cycles with `out_valid && !out_ready`, saturating.

## Operation
- Accept event: `in_valid && in_ready`. Pop event: `out_valid && out_ready`.
- **Main register (always present)**
  - Accept with the main register empty, or accept together with a pop: `out_data <= in_data`, `out_valid <= 1`.
  - Pop without accept: `out_valid <= 0`.
  - `out_data` is not cleared on pop; it holds its last value.
  - Stall (`out_valid && !out_ready`): `out_data` and `out_valid` hold.
- **flush**
  - Highest priority after `rst`. Next cycle `out_valid = 0` and every skid entry is invalid.
  - `in_ready = 0` while `flush = 1`, so no accept happens in a flush cycle.
  - `out_data` is not cleared.
  - A pop in the same cycle as `flush` still counts downstream: `out_valid` and `out_data` are valid in that cycle.
- **stall_cnt**
  - Increments every cycle in which `out_valid && !out_ready`.
  - Saturates at 2^CNT_W−1.
  - Cleared only by `rst`; `flush` does not clear it.
- **Reset values:** `out_valid = 0`, `out_data = 0`, `stall_cnt = 0`, skid empty. `in_ready` follows the rules below, with `out_valid` and skid state as reset.
- **Reset mid-transfer:** all in-flight bundles are discarded with no pop; the first accept after `rst` is released is the next bundle the stage sees.

## Timing
- Latency is 1 cycle from accept to `out_valid`, in both configurations.
- Throughput is 1 bundle per cycle while `out_ready` stays high.
- Without skid:
  - `in_ready = !flush && (!out_valid || out_ready)`.
  - This is a combinational path from `out_ready` to `in_ready`.
- With skid:
  - `in_ready = !flush && !skid_valid`. It is registered state only; no combinational dependence on `out_ready`.
- Handshake rule: `in_data` is sampled only at the rising edge where the accept event is true.
- Handshake rule: `out_data` must be stable while `out_valid && !out_ready`.

## Configuration
- Macro: `PIPE_STAGE_SKID_EN`.
- **Defined:** adds one skid entry, giving a total capacity of 2 bundles.
  - Accept while the main register is full and not popping: the bundle goes to the skid entry, `skid_valid <= 1`, and `in_ready` falls next cycle.
  - Pop while the skid entry is full: skid moves to main, `out_valid` stays 1, `skid_valid <= 0`.
  - Order is strictly FIFO.
  - Simultaneous pop and accept with the skid entry full cannot occur, because `in_ready = 0` in that state.
- **Undefined:** single entry, capacity 1, combinational ready as described in Timing. No skid storage is synthesised.

## Test plan
- **Reset:** drive `in_valid = 1`, `in_data = 74'h1234` and `rst = 1` for 2 cycles. Required: `out_valid = 0`, `out_data = 0`, `stall_cnt = 0`. Release `rst` with `out_ready = 1`: `out_data = 74'h1234` and `out_valid = 1` one cycle later.
- **Streaming:** `out_ready = 1`, `in_data` = 1, 2, 3, 4 on consecutive cycles. Required: `out_data` = 1, 2, 3, 4 one cycle later each, `in_ready` constant 1, `stall_cnt` stays 0.
- **Stall:** hold `out_ready = 0` for 5 cycles with bundle 7 in the main register.
  - Required: `out_data` stays 7 and `stall_cnt = 5`.
  - With the skid buffer, one extra bundle 8 is accepted and `in_ready` then drops to 0.
  - On release of `out_ready`, the outputs are 7 then 8 on consecutive cycles, with no loss or duplication.
- **Flush:** with the stage full (and the skid entry full when enabled), assert `flush` for 1 cycle with `in_valid = 1`. Required: `in_ready = 0` in that cycle, `out_valid = 0` the next cycle, and no flushed bundle ever appears downstream.
- **Saturation:** set `CNT_W = 4` and stall for 20 cycles. Required: `stall_cnt = 15`, with no wrap.
- **Reset mid-stall:** assert `rst` while `stall_cnt = 3`, and with the skid entry full when enabled. Required: next cycle `stall_cnt = 0`, `out_valid = 0`, `in_ready = 1`.
